// File: rtl/frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : frame_transmitter
// Description : Sends one 18-byte telemetry frame (sync, mode, sequence,
//               az/el/range payload, trailer, 16-bit word checksum) through
//               a byte-wide UART handshake, with a per-byte ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_transmitter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [18:0] i_az,
    input  logic [18:0] i_el,
    input  logic [25:0] i_range,
    input  logic [2:0]  i_tracking_mode,
    input  logic        tx_complete,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [63:0]      payload;
    logic [2:0]       mode;
    logic [7:0]       seq;
    logic [4:0]       index;
    logic [15:0]      acc;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       next_index;
    logic [7:0]       next_byte;

    assign next_index = index + 5'd1;

    // Byte that follows the one currently on tx_data; byte 0 is the constant
    // sync byte, so the start edge never needs this mux.
    always_comb begin
        next_byte = 8'h00;
        case (next_index)
            5'd1:    next_byte = 8'h16;
            5'd2:    next_byte = {5'b00000, mode};
            5'd3:    next_byte = seq;
            5'd6:    next_byte = payload[63:56];
            5'd7:    next_byte = payload[55:48];
            5'd8:    next_byte = payload[47:40];
            5'd9:    next_byte = payload[39:32];
            5'd10:   next_byte = payload[31:24];
            5'd11:   next_byte = payload[23:16];
            5'd12:   next_byte = payload[15:8];
            5'd13:   next_byte = payload[7:0];
            5'd14:   next_byte = 8'h80;
            5'd16:   next_byte = acc[15:8];
            5'd17:   next_byte = acc[7:0];
            default: next_byte = 8'h00;
        endcase
    end

    // Frame sequencer: handshake, checksum accumulation, timeout and flags.
    always_ff @(posedge system_clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
            seq      <= 8'h00;
            index    <= 5'd0;
            acc      <= 16'h0000;
            wait_cnt <= '0;
            payload  <= 64'h0;
            mode     <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        payload  <= {i_az, i_el, i_range};
                        mode     <= i_tracking_mode;
                        index    <= 5'd0;
                        acc      <= 16'h0000;
                        o_error  <= 1'b0;
                        o_busy   <= 1'b1;
                        tx_start <= 1'b1;
                        tx_data  <= 8'h16;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // Checksum covers bytes 0..15 as big-endian 16-bit words;
                    // tx_data already holds the byte being sent.
                    tx_start <= 1'b0;
                    wait_cnt <= '0;
                    if (index < 5'd16) begin
                        acc <= acc + (index[0] ? {8'h00, tx_data} : {tx_data, 8'h00});
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_complete) begin
                        if (index == 5'd17) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            seq    <= seq + 8'd1;
                            state  <= DONE;
                        end else begin
                            index    <= next_index;
                            tx_data  <= next_byte;
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_transmitter
// Description : Self-checking bench for frame_transmitter with a UART-style
//               responder and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_transmitter;

    localparam int TMO = 50;

    logic        system_clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [18:0] i_az = '0;
    logic [18:0] i_el = '0;
    logic [25:0] i_range = '0;
    logic [2:0]  i_tracking_mode = '0;
    logic        tx_complete = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  cap[$];
    int          starts = 0;
    int          dones = 0;
    int          lat_fixed = 0;
    int          withhold_at = -1;
    int          rsp_count = 0;
    logic [7:0]  exp_seq = 8'h00;

    frame_transmitter #(.TIMEOUT_CYCLES(TMO)) dut (
        .system_clk      (system_clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_az            (i_az),
        .i_el            (i_el),
        .i_range         (i_range),
        .i_tracking_mode (i_tracking_mode),
        .tx_complete     (tx_complete),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame built directly from the field layout and checksum rule.
    function automatic logic [143:0] model_frame(input logic [18:0] az, input logic [18:0] el,
                                                 input logic [25:0] rg, input logic [2:0] md,
                                                 input logic [7:0] sq);
        logic [7:0]   b[18];
        logic [63:0]  v;
        logic [31:0]  sum;
        logic [143:0] f;
        v = (64'(az) << 45) | (64'(el) << 26) | 64'(rg);
        b[0] = 8'h16; b[1] = 8'h16; b[2] = {5'b0, md}; b[3] = sq;
        b[4] = 8'h00; b[5] = 8'h00;
        for (int k = 0; k < 8; k++) b[6+k] = v[63-8*k -: 8];
        b[14] = 8'h80; b[15] = 8'h00;
        sum = 0;
        for (int w = 0; w < 8; w++) sum = sum + {16'h0, b[2*w], b[2*w+1]};
        b[16] = sum[15:8]; b[17] = sum[7:0];
        f = '0;
        for (int k = 0; k < 18; k++) f[143-8*k -: 8] = b[k];
        return f;
    endfunction

    function automatic logic [143:0] pack_cap(input int off);
        logic [143:0] f;
        f = '0;
        for (int k = 0; k < 18; k++)
            if (off + k < cap.size()) f[143-8*k -: 8] = cap[off+k];
        return f;
    endfunction

    // Monitor: capture every transmitted byte and frame completion.
    initial begin : monitor
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge system_clk);
            if (tx_start) begin
                cap.push_back(tx_data);
                starts++;
                check("busy_at_tx_start", o_busy, 1);
                check("tx_start_single_cycle", prev_start, 0);
            end
            if (o_done) begin
                dones++;
                check("busy_low_at_done", o_busy, 0);
            end
            prev_start = tx_start;
        end
    end

    // UART model: acknowledges each byte after a latency, unless withheld.
    initial begin : responder
        bit         again;
        logic [7:0] held;
        int         idx;
        int         lat;
        again = 0;
        forever begin
            if (!again) @(negedge system_clk);
            again = 0;
            if (tx_start) begin
                idx = rsp_count;
                rsp_count++;
                held = tx_data;
                if (idx != withhold_at) begin
                    lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
                    repeat (lat) @(negedge system_clk);
                    check("tx_data_stable", tx_data, held);
                    tx_complete = 1'b1;
                    @(negedge system_clk);
                    tx_complete = 1'b0;
                    again = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge system_clk);
            #1;
        end
    endtask

    task automatic start_frame(input logic [18:0] az, input logic [18:0] el,
                               input logic [25:0] rg, input logic [2:0] md);
        bit seen;
        i_az = az; i_el = el; i_range = rg; i_tracking_mode = md;
        cap.delete();
        rsp_count = 0;
        i_start = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick(1);
            if (tx_start) seen = 1;
        end
        i_start = 1'b0;
        check("start_accepted", seen, 1);
        i_az = 19'($urandom); i_el = 19'($urandom);
        i_range = 26'($urandom); i_tracking_mode = 3'($urandom);
    endtask

    task automatic wait_end(output bit got_done, output bit got_err, input int budget);
        got_done = 0;
        got_err = 0;
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (o_done) begin got_done = 1; break; end
            if (o_error) begin got_err = 1; break; end
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int c = 0; c < 500 && cap.size() < n; c++) tick(1);
        check("reach_byte_count", cap.size() >= n, 1);
    endtask

    task automatic run_check(input string tag, input logic [18:0] az, input logic [18:0] el,
                             input logic [25:0] rg, input logic [2:0] md);
        bit gd, ge;
        int d0;
        d0 = dones;
        start_frame(az, el, rg, md);
        check({tag, "_error_cleared"}, o_error, 0);
        wait_end(gd, ge, 3000);
        check({tag, "_done"}, gd, 1);
        check({tag, "_len"}, cap.size(), 18);
        check({tag, "_bytes"}, pack_cap(0), model_frame(az, el, rg, md, exp_seq));
        check({tag, "_done_count"}, dones - d0, 1);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin : stimulus
        bit          gd, ge, seen;
        int          d0, s0;
        logic [18:0] az, el;
        logic [25:0] rg;
        logic [2:0]  md;

        // Reset held low for three cycles
        reset = 1'b0;
        tick(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        reset = 1'b1;
        tick(2);

        // Stray ack while idle does nothing
        tx_complete = 1'b1;
        tick(1);
        tx_complete = 1'b0;
        tick(3);
        check("idle_ack_busy", o_busy, 0);
        check("idle_ack_starts", starts, 0);

        // Directed reference frame, ack 10 cycles after each tx_start
        lat_fixed = 10;
        d0 = dones;
        start_frame(19'h3ACA, 19'h13BA, 26'h1F40, 3'd1);
        wait_end(gd, ge, 3000);
        check("ref_done", gd, 1);
        check("ref_bytes", pack_cap(0), 144'h1616_0100_0000_0759_404E_E800_1F40_8000_E5FD);
        check("ref_done_count", dones - d0, 1);
        check("ref_error", o_error, 0);
        exp_seq = 8'h01;
        lat_fixed = 0;

        // Start pulse with new fields during byte 5 is ignored
        az = 19'($urandom); el = 19'($urandom); rg = 26'($urandom); md = 3'($urandom);
        d0 = dones; s0 = starts;
        start_frame(az, el, rg, md);
        wait_bytes(6);
        i_az = ~az; i_el = ~el; i_range = ~rg; i_tracking_mode = ~md;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_end(gd, ge, 3000);
        check("guard_done", gd, 1);
        check("guard_bytes", pack_cap(0), model_frame(az, el, rg, md, exp_seq));
        check("guard_tx_starts", starts - s0, 18);
        check("guard_done_count", dones - d0, 1);
        exp_seq = exp_seq + 8'd1;

        // Ack withheld for byte 3: timeout abort
        withhold_at = 3;
        d0 = dones;
        start_frame(19'h1, 19'h2, 26'h3, 3'd4);
        wait_bytes(4);
        tick(49);
        check("tmo_error_early", o_error, 0);
        check("tmo_busy_early", o_busy, 1);
        tick(3);
        check("tmo_error", o_error, 1);
        check("tmo_busy", o_busy, 0);
        check("tmo_no_done", dones - d0, 0);
        check("tmo_bytes_sent", cap.size(), 4);
        withhold_at = -1;
        run_check("after_tmo", 19'($urandom), 19'($urandom), 26'($urandom), 3'($urandom));

        // Reset while waiting on byte 9
        withhold_at = 9;
        d0 = dones;
        start_frame(19'($urandom), 19'($urandom), 26'($urandom), 3'($urandom));
        wait_bytes(10);
        tick(4);
        reset = 1'b0;
        tick(1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        tick(1);
        reset = 1'b1;
        s0 = starts;
        tick(30);
        check("mid_rst_quiet", starts - s0, 0);
        check("mid_rst_no_done", dones - d0, 0);
        withhold_at = -1;
        exp_seq = 8'h00;
        run_check("after_rst", 19'($urandom), 19'($urandom), 26'($urandom), 3'($urandom));

        // Back-to-back frames with i_start held high
        az = 19'($urandom); el = 19'($urandom); rg = 26'($urandom); md = 3'($urandom);
        i_az = az; i_el = el; i_range = rg; i_tracking_mode = md;
        cap.delete();
        rsp_count = 0;
        i_start = 1'b1;
        wait_end(gd, ge, 3000);
        check("b2b_first_done", gd, 1);
        seen = 0;
        for (int c = 0; c < 2 && !seen; c++) begin
            tick(1);
            if (tx_start) seen = 1;
        end
        check("b2b_restart", seen, 1);
        wait_end(gd, ge, 3000);
        i_start = 1'b0;
        check("b2b_second_done", gd, 1);
        s0 = starts;
        tick(6);
        check("b2b_no_third", starts - s0, 0);
        check("b2b_len", cap.size(), 36);
        check("b2b_frame0", pack_cap(0), model_frame(az, el, rg, md, exp_seq));
        check("b2b_frame1", pack_cap(18), model_frame(az, el, rg, md, exp_seq + 8'd1));
        exp_seq = exp_seq + 8'd2;

        // Sequence wrap over 257 random frames from reset
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        exp_seq = 8'h00;
        for (int n = 0; n < 257; n++)
            run_check("wrap", 19'($urandom), 19'($urandom), 26'($urandom), 3'($urandom));
        check("wrap_seq_final", exp_seq, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
